mem_bus_arbiter: RTL
====================

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 DATA_WIDTH, default 32, data width of all data ports.
REQ-002 ADDR_WIDTH, default 32, width of all address ports.
REQ-003 TIMEOUT_CYCLES, default 256, maximum BUSY cycles without m_ack before a transaction is aborted; legal range 1..65535.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 i_req  input  1  instruction-fetch read request; held high until i_ack.
REQ-007 i_addr  input  ADDR_WIDTH  instruction-fetch address.
REQ-008 i_rdata  output  DATA_WIDTH  instruction-fetch read data.
REQ-009 i_ack  output  1  instruction-fetch completion pulse.
REQ-010 i_err  output  1  instruction-fetch timeout flag, valid with i_ack.
REQ-011 d_req  input  1  data request; held high until d_ack.
REQ-012 d_addr  input  ADDR_WIDTH  data address.
REQ-013 d_wdata  input  DATA_WIDTH  data write data.
REQ-014 d_we  input  1  data write enable (1 = write, 0 = read).
REQ-015 d_be  input  4  data byte enables.
REQ-016 d_rdata  output  DATA_WIDTH  data read data.
REQ-017 d_ack  output  1  data completion pulse.
REQ-018 d_err  output  1  data timeout flag, valid with d_ack.
REQ-019 m_addr  output  ADDR_WIDTH  address to the memory interface core port.
REQ-020 m_wdata  output  DATA_WIDTH  write data to the memory interface.
REQ-021 m_we  output  1  write enable to the memory interface.
REQ-022 m_be  output  4  byte enables to the memory interface.
REQ-023 m_req  output  1  request to the memory interface.
REQ-024 m_rdata  input  DATA_WIDTH  read data from the memory interface.
REQ-025 m_ack  input  1  acknowledge from the memory interface.

Function
REQ-026 The arbiter SHALL implement a three-state FSM: IDLE, BUSY, RESP.
REQ-027 In IDLE with any request high, the arbiter SHALL grant one requester, register m_addr/m_wdata/m_we/m_be from the granted port, set m_req=1, clear the timeout counter and enter BUSY on the next edge.
REQ-028 An instruction-fetch grant SHALL drive m_we=0, m_be=4'hF, m_wdata=0.
REQ-029 Arbitration is round-robin: on a tie the port not granted last wins; a lone requester always wins; the last-grant pointer SHALL reset to "data", so ifetch wins the first tie.
REQ-030 The m_* outputs SHALL stay constant for the entire BUSY period.
REQ-031 In BUSY with m_ack=1, the arbiter SHALL capture m_rdata into the granted port's rdata register, clear err, drop m_req and enter RESP.
REQ-032 In BUSY without m_ack, the counter SHALL increment; when it reaches TIMEOUT_CYCLES-1 the arbiter SHALL drop m_req, load rdata=0 and err=1 for the granted port, and enter RESP.
REQ-033 m_ack on the same cycle as the timeout SHALL take precedence (normal completion, err=0).
REQ-034 In RESP the granted port's ack SHALL be high for exactly one cycle, with err valid; the FSM then returns to IDLE.
REQ-035 Minimum latency: req sampled at edge T gives m_req=1 after T, and m_ack sampled at edge T+k gives x_ack=1 during the cycle following T+k.
REQ-036 i_rdata/d_rdata SHALL hold until that port's next completion; m_ack outside BUSY SHALL be ignored.
REQ-037 A request deasserted in IDLE before being granted SHALL be dropped silently; a request high in IDLE after RESP SHALL be treated as a new request.
REQ-038 The non-granted port's ack, err and rdata SHALL remain unchanged during another port's transaction.

Reset
REQ-039 Asserting rst SHALL immediately (asynchronously) force IDLE, the counter to 0, the last-grant pointer to "data", and all outputs to 0.
REQ-040 Reset during BUSY or RESP SHALL abort the transaction without any ack; after release, pending requests SHALL be arbitrated normally.

Verification
REQ-041 Reset: rst=1 with requests active -> all outputs 0 within the same cycle; no ack after release until a new grant.
REQ-042 Ifetch read: i_addr=0x0000_0100, m_ack with m_rdata=0x1234_5678 on the 3rd BUSY cycle -> m_we=0, m_be=0xF, one-cycle i_ack, i_rdata=0x1234_5678, i_err=0.
REQ-043 Data write: d_addr=0x8000_0000, d_wdata=0xCAFE_BABE, d_be=0x3, d_we=1 -> m_* match throughout BUSY; d_ack one cycle; d_err=0.
REQ-044 Tie: i_req and d_req both held high from reset -> grant order ifetch, data, ifetch, data; never two acks in one cycle.
REQ-045 Timeout: TIMEOUT_CYCLES=16, d_req to 0x2000_0000, m_ack held 0 -> m_req drops after 16 BUSY cycles; d_ack=1, d_err=1, d_rdata=0.
REQ-046 Mid-transaction reset: rst pulsed on BUSY cycle 2 -> m_req=0 immediately, no d_ack; after release, the still-high d_req is re-granted and completes.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-port (ifetch/data) round-robin arbiter onto one memory port with timeout
module mem_bus_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [DATA_WIDTH-1:0] i_rdata,
    output logic                  i_ack,
    output logic                  i_err,
    input  logic                  d_req,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    input  logic                  d_we,
    input  logic [3:0]            d_be,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_ack,
    output logic                  d_err,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic [DATA_WIDTH-1:0] m_wdata,
    output logic                  m_we,
    output logic [3:0]            m_be,
    output logic                  m_req,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    input  logic                  m_ack
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // The counter saturates at this value; reaching it without m_ack aborts the transfer.
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t                state_q, state_d;
    logic [15:0]           cnt_q, cnt_d;
    logic                  last_data_q, last_data_d;   // 1 = data port won the last grant
    logic                  sel_data_q, sel_data_d;     // 1 = data port owns the current transfer
    logic [ADDR_WIDTH-1:0] m_addr_q, m_addr_d;
    logic [DATA_WIDTH-1:0] m_wdata_q, m_wdata_d;
    logic                  m_we_q, m_we_d;
    logic [3:0]            m_be_q, m_be_d;
    logic                  m_req_q, m_req_d;
    logic [DATA_WIDTH-1:0] i_rdata_q, i_rdata_d;
    logic                  i_ack_q, i_ack_d;
    logic                  i_err_q, i_err_d;
    logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
    logic                  d_ack_q, d_ack_d;
    logic                  d_err_q, d_err_d;

    logic                  grant_data;
    logic                  done;
    logic                  done_err;
    logic [DATA_WIDTH-1:0] done_rdata;

    // Next-state logic: arbitration in IDLE, completion/timeout in BUSY, one-cycle ack in RESP.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_data_d = last_data_q;
        sel_data_d  = sel_data_q;
        m_addr_d    = m_addr_q;
        m_wdata_d   = m_wdata_q;
        m_we_d      = m_we_q;
        m_be_d      = m_be_q;
        m_req_d     = m_req_q;
        i_rdata_d   = i_rdata_q;
        i_err_d     = i_err_q;
        d_rdata_d   = d_rdata_q;
        d_err_d     = d_err_q;
        i_ack_d     = 1'b0;
        d_ack_d     = 1'b0;
        grant_data  = 1'b0;
        done        = 1'b0;
        done_err    = 1'b0;
        done_rdata  = '0;

        case (state_q)
            ST_IDLE: begin
                if (i_req || d_req) begin
                    // Data wins when alone, or on a tie when ifetch was granted last.
                    grant_data  = d_req && (!i_req || !last_data_q);
                    sel_data_d  = grant_data;
                    last_data_d = grant_data;
                    if (grant_data) begin
                        m_addr_d  = d_addr;
                        m_wdata_d = d_wdata;
                        m_we_d    = d_we;
                        m_be_d    = d_be;
                    end else begin
                        m_addr_d  = i_addr;
                        m_wdata_d = '0;
                        m_we_d    = 1'b0;
                        m_be_d    = 4'hF;
                    end
                    m_req_d = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // m_ack is checked first so it wins over a simultaneous timeout.
                if (m_ack) begin
                    done       = 1'b1;
                    done_rdata = m_rdata;
                end else if (cnt_q == CNT_LAST) begin
                    done     = 1'b1;
                    done_err = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
                if (done) begin
                    m_req_d = 1'b0;
                    state_d = ST_RESP;
                    if (sel_data_q) begin
                        d_rdata_d = done_rdata;
                        d_err_d   = done_err;
                        d_ack_d   = 1'b1;
                    end else begin
                        i_rdata_d = done_rdata;
                        i_err_d   = done_err;
                        i_ack_d   = 1'b1;
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any transfer and clears every output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            last_data_q <= 1'b1;
            sel_data_q  <= 1'b0;
            m_addr_q    <= '0;
            m_wdata_q   <= '0;
            m_we_q      <= 1'b0;
            m_be_q      <= 4'h0;
            m_req_q     <= 1'b0;
            i_rdata_q   <= '0;
            i_ack_q     <= 1'b0;
            i_err_q     <= 1'b0;
            d_rdata_q   <= '0;
            d_ack_q     <= 1'b0;
            d_err_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_data_q <= last_data_d;
            sel_data_q  <= sel_data_d;
            m_addr_q    <= m_addr_d;
            m_wdata_q   <= m_wdata_d;
            m_we_q      <= m_we_d;
            m_be_q      <= m_be_d;
            m_req_q     <= m_req_d;
            i_rdata_q   <= i_rdata_d;
            i_ack_q     <= i_ack_d;
            i_err_q     <= i_err_d;
            d_rdata_q   <= d_rdata_d;
            d_ack_q     <= d_ack_d;
            d_err_q     <= d_err_d;
        end
    end

    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign m_we    = m_we_q;
    assign m_be    = m_be_q;
    assign m_req   = m_req_q;
    assign i_rdata = i_rdata_q;
    assign i_ack   = i_ack_q;
    assign i_err   = i_err_q;
    assign d_rdata = d_rdata_q;
    assign d_ack   = d_ack_q;
    assign d_err   = d_err_q;

endmodule
